es_decode_stage_ctrl: RTL and testbench
=======================================

Name: es_decode_stage_ctrl

Overview:
Owns the IF/ID pipeline register and sequences the decode stage of the 5-stage RV32I core. It decides each cycle whether the instruction feeding the ID-stage immediate decoder and register file advances, holds for a load-use hazard, or is squashed by a taken branch/jump. It also tracks the instruction currently in EX so it can detect load-use hazards, and counts inserted stall cycles for performance monitoring.

Parameters:
size, 32, instruction/PC width
CNT_W, 16, width of saturating stall counter
NOP, 32'h00000013, instruction value (addi x0,x0,0) held in IF/ID on reset/flush

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
if_instr  input  size  instruction fetched this cycle
if_pc  input  size  PC of if_instr
if_valid  input  1  if_instr is a real instruction
mem_stall  input  1  global freeze from MEM stage (data memory busy)
ex_flush  input  1  branch/jump resolved taken in EX; squash IF and ID
id_instr  output  size  registered IF/ID instruction, drives decoder/imm gen/regfile
id_pc  output  size  registered IF/ID PC
id_valid  output  1  id_instr is live
pc_stall  output  1  hold PC and fetch (combinational)
idex_valid_next  output  1  valid bit to load into ID/EX this cycle (0 = bubble)
hazard  output  1  load-use hazard detected this cycle (combinational)
stall_cnt  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, immediate): id_instr=NOP, id_pc=0, id_valid=0, EX tracker cleared (ex_is_load=0, ex_rd=0), stall_cnt=0.
- Decode of id_instr: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20].
- rs1 used: all opcodes except LUI 0110111, AUIPC 0010111, JAL 1101111. rs2 used: R-type 0110011, STORE 0100011, BRANCH 1100011.
- hazard = id_valid & ex_is_load & (ex_rd!=0) & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
- Priority per cycle: mem_stall > ex_flush > hazard > advance.
- mem_stall=1: all registers hold (IF/ID, tracker, stall_cnt); pc_stall=1; idex_valid_next=id_valid & ~hazard (ID/EX is also frozen externally, value informational).
- ex_flush=1 (no mem_stall): IF/ID <= {NOP, if_pc, 0}; tracker cleared; idex_valid_next=0; pc_stall=0 (PC loads target).
- hazard=1 (no mem_stall/flush): IF/ID holds; pc_stall=1; idex_valid_next=0; tracker cleared (bubble enters EX); stall_cnt += 1, saturating at 2^CNT_W-1. Hazard resolves next cycle, so each load-use costs exactly 1 stall cycle.
- Advance: IF/ID <= {if_valid?if_instr:NOP, if_pc, if_valid}; pc_stall=0; idex_valid_next=id_valid; tracker <= {ex_is_load = id_valid & opcode==0000011, ex_rd = rd}.
- hazard and pc_stall are combinational from registered state plus mem_stall/ex_flush; no combinational path from if_* to any output.
- Loads with rd=x0 never stall. Flush coincident with hazard: flush wins, stall_cnt unchanged.

Decomposition:
- Shared package: RV32I opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL), NOP constant.
- One sub-module natural: es_hazard_detect (combinational rs-used decode + compare), instantiated once.

Test Plan:
- Reset mid-run: assert reset with id_valid=1 -> id_instr=0x00000013, id_valid=0, stall_cnt=0 immediately, before next clk edge.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> hazard=1, pc_stall=1, idex_valid_next=0 for exactly 1 cycle; add advances next cycle; stall_cnt=1.
- No false stall: lw x0,0(x1) then add x6,x0,x0; and lw x5 then lui x5,0x12345 -> hazard=0 both cases.
- Flush vs hazard: load-use pair with ex_flush=1 same cycle -> id_valid=0, id_instr=NOP next cycle, stall_cnt unchanged, tracker cleared.
- mem_stall freeze: lw x5 in EX, add x6,x5,x2 in ID, mem_stall=1 for 3 cycles -> all state held, stall_cnt increments only once after release.
- Saturation: CNT_W=4, force 20 load-use stalls -> stall_cnt stops at 15.

Source files
------------

// File: rtl/es_decode_stage_ctrl_pkg.sv
// rtl/es_decode_stage_ctrl_pkg.sv - RV32I opcode constants shared by the decode-stage control
package es_decode_stage_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/es_decode_stage_ctrl_hazard.sv
// rtl/es_decode_stage_ctrl_hazard.sv - load-use hazard detect for the instruction in ID
module es_hazard_detect
   import es_decode_stage_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic       id_valid_i,
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_rd_i,
   output logic       hazard_o
);

   logic rs1_used;
   logic rs2_used;

   always_comb begin
      rs1_used = !(opcode_i == OP_LUI || opcode_i == OP_AUIPC || opcode_i == OP_JAL);
      rs2_used = (opcode_i == OP_RTYPE || opcode_i == OP_STORE || opcode_i == OP_BRANCH);
      // a load into x0 never produces a value worth waiting for
      hazard_o = id_valid_i && ex_is_load_i && (ex_rd_i != 5'd0) &&
                 ((rs1_used && (rs1_i == ex_rd_i)) || (rs2_used && (rs2_i == ex_rd_i)));
   end

endmodule

// File: rtl/es_decode_stage_ctrl.sv
// rtl/es_decode_stage_ctrl.sv - IF/ID register, EX load tracker and decode-stage stall/flush sequencing
module es_decode_stage_ctrl
   import es_decode_stage_ctrl_pkg::*;
#(
   parameter int              size  = 32,
   parameter int              CNT_W = 16,
   parameter logic [size-1:0] NOP   = NOP_INSTR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [size-1:0]  if_instr,
   input  logic [size-1:0]  if_pc,
   input  logic             if_valid,
   input  logic             mem_stall,
   input  logic             ex_flush,
   output logic [size-1:0]  id_instr,
   output logic [size-1:0]  id_pc,
   output logic             id_valid,
   output logic             pc_stall,
   output logic             idex_valid_next,
   output logic             hazard,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [size-1:0]  id_instr_q, id_instr_d;
   logic [size-1:0]  id_pc_q, id_pc_d;
   logic             id_valid_q, id_valid_d;
   logic             ex_is_load_q, ex_is_load_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   es_hazard_detect u_hazard (
      .opcode_i     (id_instr_q[6:0]),
      .rs1_i        (id_instr_q[19:15]),
      .rs2_i        (id_instr_q[24:20]),
      .id_valid_i   (id_valid_q),
      .ex_is_load_i (ex_is_load_q),
      .ex_rd_i      (ex_rd_q),
      .hazard_o     (hazard)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_instr_q   <= NOP;
         id_pc_q      <= '0;
         id_valid_q   <= 1'b0;
         ex_is_load_q <= 1'b0;
         ex_rd_q      <= 5'd0;
         stall_cnt_q  <= '0;
      end else begin
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_valid_q   <= id_valid_d;
         ex_is_load_q <= ex_is_load_d;
         ex_rd_q      <= ex_rd_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   always_comb begin
      id_instr_d      = id_instr_q;
      id_pc_d         = id_pc_q;
      id_valid_d      = id_valid_q;
      ex_is_load_d    = ex_is_load_q;
      ex_rd_d         = ex_rd_q;
      stall_cnt_d     = stall_cnt_q;
      pc_stall        = 1'b0;
      idex_valid_next = id_valid_q;

      if (mem_stall) begin
         // whole pipe frozen; idex_valid_next only reports what ID would send
         pc_stall        = 1'b1;
         idex_valid_next = id_valid_q && !hazard;
      end else if (ex_flush) begin
         id_instr_d      = NOP;
         id_pc_d         = if_pc;
         id_valid_d      = 1'b0;
         ex_is_load_d    = 1'b0;
         ex_rd_d         = 5'd0;
         idex_valid_next = 1'b0;
      end else if (hazard) begin
         // bubble goes to EX, so the hazard is gone next cycle
         pc_stall        = 1'b1;
         idex_valid_next = 1'b0;
         ex_is_load_d    = 1'b0;
         ex_rd_d         = 5'd0;
         if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end else begin
         ex_is_load_d = id_valid_q && (id_instr_q[6:0] == OP_LOAD);
         ex_rd_d      = id_instr_q[11:7];
         id_instr_d   = if_valid ? if_instr : NOP;
         id_pc_d      = if_pc;
         id_valid_d   = if_valid;
      end
   end

   assign id_instr  = id_instr_q;
   assign id_pc     = id_pc_q;
   assign id_valid  = id_valid_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_es_decode_stage_ctrl.sv
// tb/tb_es_decode_stage_ctrl.sv - scoreboard bench for es_decode_stage_ctrl with reference model
module tb_es_decode_stage_ctrl;

   localparam int CW  = 4;
   localparam int CAP = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [31:0]   if_instr = 32'h0;
   logic [31:0]   if_pc = 32'h0;
   logic          if_valid = 1'b0;
   logic          mem_stall = 1'b0;
   logic          ex_flush = 1'b0;
   logic [31:0]   id_instr;
   logic [31:0]   id_pc;
   logic          id_valid;
   logic          pc_stall;
   logic          idex_valid_next;
   logic          hazard;
   logic [CW-1:0] stall_cnt;

   es_decode_stage_ctrl #(.size(32), .CNT_W(CW), .NOP(32'h00000013)) dut (
      .clk             (clk),
      .reset           (reset),
      .if_instr        (if_instr),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .mem_stall       (mem_stall),
      .ex_flush        (ex_flush),
      .id_instr        (id_instr),
      .id_pc           (id_pc),
      .id_valid        (id_valid),
      .pc_stall        (pc_stall),
      .idex_valid_next (idex_valid_next),
      .hazard          (hazard),
      .stall_cnt       (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        pcs;
      logic        idexv;
      logic        hz;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   // reference pipeline state: what sits in ID, what sits in EX
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_ex_load;
   logic [4:0]  m_ex_rd;
   int          m_cnt;

   function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
      logic [4:0] d, a, b;
      d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0];
      return {7'b0, b, a, 3'b010, d, op};
   endfunction

   function automatic bit reads_rs1(input logic [31:0] ins);
      return !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
   endfunction

   function automatic bit reads_rs2(input logic [31:0] ins);
      return ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit model_hazard();
      if (!m_valid || !m_ex_load || m_ex_rd == 5'd0) return 1'b0;
      return (reads_rs1(m_instr) && m_instr[19:15] == m_ex_rd) ||
             (reads_rs2(m_instr) && m_instr[24:20] == m_ex_rd);
   endfunction

   task automatic model_reset();
      m_instr = 32'h00000013; m_pc = 32'h0; m_valid = 1'b0;
      m_ex_load = 1'b0; m_ex_rd = 5'd0; m_cnt = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // one cycle: drive inputs after negedge, queue the expected view, advance the model
   task automatic step(input bit r, input logic [31:0] ins, input logic [31:0] pc,
                       input bit v, input bit ms, input bit fl);
      exp_t e;
      bit   hz;
      @(negedge clk);
      reset = r; if_instr = ins; if_pc = pc; if_valid = v; mem_stall = ms; ex_flush = fl;
      if (r) model_reset();
      hz      = model_hazard();
      e.instr = m_instr;
      e.pc    = m_pc;
      e.valid = m_valid;
      e.hz    = hz;
      e.pcs   = ms || (!fl && hz);
      e.idexv = ms ? (m_valid && !hz) : (!fl && !hz && m_valid);
      e.cnt   = 32'(m_cnt);
      exp_q.push_back(e);
      if (!r) begin
         if (ms) begin
         end else if (fl) begin
            m_instr = 32'h00000013; m_pc = pc; m_valid = 1'b0;
            m_ex_load = 1'b0; m_ex_rd = 5'd0;
         end else if (hz) begin
            m_ex_load = 1'b0; m_ex_rd = 5'd0;
            if (m_cnt < CAP) m_cnt = m_cnt + 1;
         end else begin
            m_ex_load = m_valid && (m_instr[6:0] == 7'b0000011);
            m_ex_rd   = m_instr[11:7];
            m_instr   = v ? ins : 32'h00000013;
            m_pc      = pc;
            m_valid   = v;
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] op;
      case ($urandom_range(0, 9))
         0, 1, 2: op = 7'b0000011;
         3:       op = 7'b0100011;
         4:       op = 7'b1100011;
         5, 6:    op = 7'b0110011;
         7:       op = 7'b0110111;
         8:       op = 7'b1101111;
         default: op = 7'b0010011;
      endcase
      return enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("id_instr", id_instr, e.instr);
            chk("id_pc", id_pc, e.pc);
            chk("id_valid", 32'(id_valid), 32'(e.valid));
            chk("hazard", 32'(hazard), 32'(e.hz));
            chk("pc_stall", 32'(pc_stall), 32'(e.pcs));
            chk("idex_valid_next", 32'(idex_valid_next), 32'(e.idexv));
            chk("stall_cnt", 32'(stall_cnt), e.cnt);
         end
      end
   end

   initial begin : stimulus
      logic [31:0] lw5, add6, lw0, addz, lui5, nxt;
      lw5  = 32'h0000A283;
      add6 = 32'h00228333;
      lw0  = 32'h0000A003;
      addz = 32'h00000333;
      lui5 = 32'h123452B7;
      nxt  = enc(7'b0010011, 1, 1, 0);

      step(1, 0, 0, 0, 0, 0);
      step(0, lw5, 32'h100, 1, 0, 0);
      step(0, add6, 32'h104, 1, 0, 0);
      step(0, nxt, 32'h108, 1, 0, 0);
      step(0, nxt, 32'h108, 1, 0, 0);
      step(0, nxt, 32'h10c, 1, 0, 0);

      step(0, lw0, 32'h200, 1, 0, 0);
      step(0, addz, 32'h204, 1, 0, 0);
      step(0, lw5, 32'h208, 1, 0, 0);
      step(0, lui5, 32'h20c, 1, 0, 0);
      step(0, nxt, 32'h210, 1, 0, 0);

      step(0, lw5, 32'h300, 1, 0, 0);
      step(0, add6, 32'h304, 1, 0, 0);
      step(0, nxt, 32'h308, 1, 0, 1);
      step(0, nxt, 32'h400, 1, 0, 0);

      step(0, lw5, 32'h500, 1, 0, 0);
      step(0, add6, 32'h504, 1, 0, 0);
      repeat (3) step(0, nxt, 32'h508, 1, 1, 0);
      step(0, nxt, 32'h508, 1, 0, 0);
      step(0, nxt, 32'h508, 1, 0, 0);

      step(0, nxt, 32'h50c, 1, 0, 0);
      step(1, nxt, 32'h50c, 1, 0, 0);
      step(0, nxt, 32'h0, 0, 0, 0);

      for (int i = 0; i < 21; i++) begin
         step(0, lw5, 32'h600, 1, 0, 0);
         step(0, add6, 32'h604, 1, 0, 0);
         step(0, add6, 32'h604, 1, 0, 0);
      end
      step(0, nxt, 32'h608, 1, 0, 0);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 99) == 0, rand_instr(), $urandom, $urandom_range(0, 4) != 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      end

      step(0, nxt, 32'h0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
